// File: rtl/shifter_if.sv
// Operand/result bundle for the 16x16 shift-and-add multiplier.
// SHIFTER_ZERO_FLAG_EN adds the registered zero flag zero_q.
interface shifter_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        isMul;
  logic [31:0] result;
  logic [31:0] result_q;
  logic        valid_q;
`ifdef SHIFTER_ZERO_FLAG_EN
  logic        zero_q;

  modport master (output A, output B, output isMul,
                  input result, input result_q, input valid_q, input zero_q);
  modport slave  (input A, input B, input isMul,
                  output result, output result_q, output valid_q, output zero_q);
`else
  modport master (output A, output B, output isMul,
                  input result, input result_q, input valid_q);
  modport slave  (input A, input B, input isMul,
                  output result, output result_q, output valid_q);
`endif
endinterface

// File: rtl/shifter.sv
// Unsigned 16x16 shift-and-add multiplier with combinational and registered outputs.
// Optional feature macro: SHIFTER_ZERO_FLAG_EN adds registered zero flag zero_q.
module shifter (
  input  logic     clk,
  input  logic     rst_n,
  shifter_if.slave bus
);

  logic [15:0] a_s;
  logic [15:0] b_s;
  logic [31:0] prod_s;
  logic [31:0] result_s;
  logic [31:0] result_r;
  logic        valid_r;
  logic        unused_upper_s;

  assign a_s = bus.A[15:0];
  assign b_s = bus.B[15:0];
  // Upper operand halves are intentionally ignored.
  assign unused_upper_s = ^{bus.A[31:16], bus.B[31:16]};

  // Sum of the sixteen partial products selected by the bits of B.
  always_comb begin
    prod_s = 32'd0;
    for (int i = 0; i < 16; i++) begin
      if (b_s[i]) begin
        prod_s = prod_s + ({16'd0, a_s} << i);
      end else begin
        prod_s = prod_s;
      end
    end
  end

  // Gate the product with the multiply enable.
  always_comb begin
    result_s = 32'd0;
    if (bus.isMul) begin
      result_s = prod_s;
    end else begin
      result_s = 32'd0;
    end
  end

  // Capture the product and its qualifier every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 32'd0;
      valid_r  <= 1'b0;
    end else begin
      result_r <= result_s;
      valid_r  <= bus.isMul;
    end
  end

  assign bus.result   = result_s;
  assign bus.result_q = result_r;
  assign bus.valid_q  = valid_r;

`ifdef SHIFTER_ZERO_FLAG_EN
  logic zero_r;

  // Flag a valid product that came out zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
    end else begin
      zero_r <= bus.isMul && (result_s == 32'd0);
    end
  end

  assign bus.zero_q = zero_r;
`endif

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed corner cases, random operands
// against an arithmetic reference, and asynchronous reset behaviour.
module tb_shifter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  shifter_if bus ();

  shifter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic m);
    logic [31:0] ax;
    logic [31:0] bx;
    ax = {16'd0, a[15:0]};
    bx = {16'd0, b[15:0]};
    return m ? (ax * bx) : 32'd0;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic m);
    logic [31:0] exp;
    exp = ref_mul(a, b, m);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.isMul = m;
    #1;
    check_val({tag, "/result"}, bus.result, exp);
    @(posedge clk);
    #1;
    check_val({tag, "/result_q"}, bus.result_q, exp);
    check_val({tag, "/valid_q"}, {31'd0, bus.valid_q}, {31'd0, m});
`ifdef SHIFTER_ZERO_FLAG_EN
    check_val({tag, "/zero_q"}, {31'd0, bus.zero_q}, {31'd0, (m && exp == 32'd0)});
`endif
  endtask

  initial begin
    logic [31:0] held;
    rst_n     = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.isMul = 1'b0;
    #12;
    check_val("reset/result_q", bus.result_q, 32'd0);
    check_val("reset/valid_q", {31'd0, bus.valid_q}, 32'd0);
    // Combinational path must work while reset is held.
    bus.A     = 32'h0000_0005;
    bus.B     = 32'h0000_0007;
    bus.isMul = 1'b1;
    #1;
    check_val("reset/comb", bus.result, 32'h0000_0023);
    @(posedge clk);
    #1;
    check_val("reset/hold_q", bus.result_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("dir_ones_off", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("dir_5x7", 32'h0000_0005, 32'h0000_0007, 1'b1);
    run_op("dir_max", 32'h0000_FFFF, 32'h0000_FFFF, 1'b1);
    check_val("dir_max/const", bus.result_q, 32'hFFFE_0001);
    run_op("dir_upper", 32'hFFFF_0003, 32'hFFFF_0002, 1'b1);
    check_val("dir_upper/const", bus.result, 32'h0000_0006);
    run_op("dir_zero", 32'h0000_1234, 32'h0000_0000, 1'b1);

    // Registered output must hold while inputs change between edges.
    run_op("hold_setup", 32'h0000_00FF, 32'h0000_0101, 1'b1);
    held = bus.result_q;
    @(negedge clk);
    bus.A = 32'h0000_0003;
    bus.B = 32'h0000_0009;
    #2;
    check_val("hold/result_q", bus.result_q, held);
    check_val("hold/comb", bus.result, 32'h0000_001B);

    for (int i = 0; i < 20; i++) begin
      run_op("rand_mul", $urandom, $urandom, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      run_op("rand_off", $urandom, $urandom, 1'b0);
    end

    // Asynchronous reset pulse between edges discards the held product.
    run_op("pre_rst", 32'h0000_0011, 32'h0000_0013, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst/result_q", bus.result_q, 32'd0);
    check_val("async_rst/valid_q", {31'd0, bus.valid_q}, 32'd0);
`ifdef SHIFTER_ZERO_FLAG_EN
    check_val("async_rst/zero_q", {31'd0, bus.zero_q}, 32'd0);
`endif
    check_val("async_rst/comb", bus.result, 32'h0000_0143);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'h0000_8000, 32'h0000_0002, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
